// File: rtl/traffic_sequencer.sv
// Traffic-light sequencer: timed GREEN/YELLOW/RED cycle with a latched pedestrian
// request, a WALK/CLEAR crossing phase and a flashing-yellow night mode.
`timescale 1ns/1ps

module traffic_sequencer #(
    parameter logic [11:0] C_COLORS      = {3'b100, 3'b010, 3'b110, 3'b111},
    parameter int unsigned C_TICK_CYCLES = 100000,
    parameter int unsigned C_T_GREEN_MIN = 5000,
    parameter int unsigned C_T_GREEN_MAX = 20000,
    parameter int unsigned C_T_YELLOW    = 3000,
    parameter int unsigned C_T_RED       = 2000,
    parameter int unsigned C_T_WALK      = 8000,
    parameter int unsigned C_T_CLEAR     = 2000,
    parameter int unsigned C_T_FLASH     = 500
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [1:0]  inPedestrian,
    input  logic        inFlash,
    output logic [11:0] outRGB,
    output logic [2:0]  outLight,
    output logic        outPedWait
);

    typedef enum logic [2:0] {
        ST_RED    = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_WALK   = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_FLASH  = 3'd5
    } state_t;

    localparam logic [31:0] TICK_LAST      = 32'(C_TICK_CYCLES - 1);
    localparam logic [15:0] GREEN_MIN_LAST = 16'(C_T_GREEN_MIN - 1);
    localparam logic [15:0] GREEN_MAX_LAST = 16'(C_T_GREEN_MAX - 1);
    localparam logic [15:0] YELLOW_LAST    = 16'(C_T_YELLOW - 1);
    localparam logic [15:0] RED_LAST       = 16'(C_T_RED - 1);
    localparam logic [15:0] WALK_LAST      = 16'(C_T_WALK - 1);
    localparam logic [15:0] CLEAR_LAST     = 16'(C_T_CLEAR - 1);
    localparam logic [15:0] FLASH_LAST     = 16'(C_T_FLASH - 1);

    localparam logic [11:0] MASK_RED    = 12'hE00;
    localparam logic [11:0] MASK_GREEN  = 12'h1C0;
    localparam logic [11:0] MASK_YELLOW = 12'h038;
    localparam logic [11:0] MASK_WALK   = 12'h007;

    state_t      state;
    state_t      state_next;
    logic [31:0] prescaler;
    logic [15:0] count;
    logic        pending;
    logic        flash_bit;
    logic        tick;
    logic        flash_toggle;
    logic        entering;
    logic [11:0] mask;

    assign tick         = (prescaler == TICK_LAST);
    assign flash_toggle = (state == ST_FLASH) && tick && (count == FLASH_LAST);
    assign entering     = (state_next != state);

    always_comb begin
        state_next = state;
        case (state)
            ST_RED: begin
                if (tick && count == RED_LAST) begin
                    if (inFlash)      state_next = ST_FLASH;
                    else if (pending) state_next = ST_WALK;
                    else              state_next = ST_GREEN;
                end
            end
            ST_GREEN: begin
                // Early exit once the minimum has elapsed and someone is waiting
                if (tick && (count == GREEN_MAX_LAST ||
                             (count >= GREEN_MIN_LAST && (pending || inFlash))))
                    state_next = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (tick && count == YELLOW_LAST)
                    state_next = inFlash ? ST_FLASH : ST_RED;
            end
            ST_WALK: begin
                if (tick && count == WALK_LAST)
                    state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (tick && count == CLEAR_LAST)
                    state_next = inFlash ? ST_FLASH : ST_GREEN;
            end
            ST_FLASH: begin
                if (!inFlash)
                    state_next = ST_RED;
            end
            default: state_next = ST_RED;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_RED;
            prescaler <= '0;
            count     <= '0;
            pending   <= 1'b0;
            flash_bit <= 1'b1;
        end else begin
            state <= state_next;

            if (entering) begin
                prescaler <= '0;
                count     <= '0;
            end else if (tick) begin
                prescaler <= '0;
                count     <= flash_toggle ? 16'd0 : count + 16'd1;
            end else begin
                prescaler <= prescaler + 32'd1;
            end

            if (entering && state_next == ST_FLASH)
                flash_bit <= 1'b1;
            else if (flash_toggle)
                flash_bit <= ~flash_bit;

            // Entering WALK serves the request, so the clear beats a same-cycle press
            if (entering && state_next == ST_WALK)
                pending <= 1'b0;
            else if (state != ST_WALK && |inPedestrian)
                pending <= 1'b1;
        end
    end

    always_comb begin
        mask = MASK_RED;
        case (state)
            ST_RED:    mask = MASK_RED;
            ST_CLEAR:  mask = MASK_RED;
            ST_WALK:   mask = MASK_RED | MASK_WALK;
            ST_GREEN:  mask = MASK_GREEN;
            ST_YELLOW: mask = MASK_YELLOW;
            ST_FLASH:  mask = flash_bit ? MASK_YELLOW : 12'h000;
            default:   mask = MASK_RED;
        endcase
    end

    assign outRGB     = C_COLORS & mask;
    assign outLight   = state;
    assign outPedWait = pending;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer with a 4-cycle tick: idle cycle, pedestrian
// requests, night mode, flash/pending priority and asynchronous reset.
`timescale 1ns/1ps

module tb_traffic_sequencer;

    localparam logic [2:0]  L_RED    = 3'd0;
    localparam logic [2:0]  L_GREEN  = 3'd1;
    localparam logic [2:0]  L_YELLOW = 3'd2;
    localparam logic [2:0]  L_WALK   = 3'd3;
    localparam logic [2:0]  L_CLEAR  = 3'd4;
    localparam logic [2:0]  L_FLASH  = 3'd5;

    localparam logic [11:0] RGB_RED    = 12'h800;
    localparam logic [11:0] RGB_GREEN  = 12'h080;
    localparam logic [11:0] RGB_YELLOW = 12'h030;
    localparam logic [11:0] RGB_WALK   = 12'h807;
    localparam logic [11:0] RGB_OFF    = 12'h000;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [1:0]  inPedestrian = 2'b00;
    logic        inFlash = 1'b0;
    logic [11:0] outRGB;
    logic [2:0]  outLight;
    logic        outPedWait;

    int checks = 0;
    int failures = 0;

    traffic_sequencer #(
        .C_COLORS      ({3'b100, 3'b010, 3'b110, 3'b111}),
        .C_TICK_CYCLES (4),
        .C_T_GREEN_MIN (3),
        .C_T_GREEN_MAX (6),
        .C_T_YELLOW    (2),
        .C_T_RED       (2),
        .C_T_WALK      (3),
        .C_T_CLEAR     (1),
        .C_T_FLASH     (2)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .inPedestrian (inPedestrian),
        .inFlash      (inFlash),
        .outRGB       (outRGB),
        .outLight     (outLight),
        .outPedWait   (outPedWait)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [2:0] light,
                                input logic [11:0] rgb, input logic pw);
        checks++;
        assert (outLight === light) else begin
            failures++;
            $error("[TB] FAIL %s outLight got %0d expected %0d at %0t", tag, outLight, light, $time);
        end
        checks++;
        assert (outRGB === rgb) else begin
            failures++;
            $error("[TB] FAIL %s outRGB got 0x%03h expected 0x%03h at %0t", tag, outRGB, rgb, $time);
        end
        checks++;
        assert (outPedWait === pw) else begin
            failures++;
            $error("[TB] FAIL %s outPedWait got %0b expected %0b at %0t", tag, outPedWait, pw, $time);
        end
    endtask

    // Checks every cycle of a phase, leaving the bench on the first cycle of the next one
    task automatic run_phase(input string tag, input logic [2:0] light,
                             input logic [11:0] rgb, input logic pw, input int len);
        for (int i = 0; i < len; i++) begin
            check_output($sformatf("%s[%0d]", tag, i), light, rgb, pw);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_output("reset", L_RED, RGB_RED, 1'b0);
        rstb = 1'b1;

        $display("[TB] idle cycle");
        run_phase("idle_red",    L_RED,    RGB_RED,    1'b0, 8);
        run_phase("idle_green",  L_GREEN,  RGB_GREEN,  1'b0, 24);
        run_phase("idle_yellow", L_YELLOW, RGB_YELLOW, 1'b0, 8);
        run_phase("idle_red2",   L_RED,    RGB_RED,    1'b0, 8);

        $display("[TB] pedestrian request");
        run_phase("ped_green_a", L_GREEN, RGB_GREEN, 1'b0, 1);
        inPedestrian = 2'b01;
        run_phase("ped_green_b", L_GREEN, RGB_GREEN, 1'b0, 1);
        inPedestrian = 2'b00;
        run_phase("ped_green_c", L_GREEN,  RGB_GREEN,  1'b1, 10);
        run_phase("ped_yellow",  L_YELLOW, RGB_YELLOW, 1'b1, 8);
        run_phase("ped_red",     L_RED,    RGB_RED,    1'b1, 8);
        run_phase("ped_walk_a",  L_WALK,   RGB_WALK,   1'b0, 3);
        inPedestrian = 2'b10;
        run_phase("ped_walk_b",  L_WALK,   RGB_WALK,   1'b0, 5);
        inPedestrian = 2'b00;
        run_phase("ped_walk_c",  L_WALK,   RGB_WALK,   1'b0, 4);
        run_phase("ped_clear",   L_CLEAR,  RGB_RED,    1'b0, 4);
        run_phase("walkreq_green",  L_GREEN,  RGB_GREEN,  1'b0, 24);
        run_phase("walkreq_yellow", L_YELLOW, RGB_YELLOW, 1'b0, 8);
        run_phase("walkreq_red",    L_RED,    RGB_RED,    1'b0, 8);

        $display("[TB] night mode");
        run_phase("night_green_a", L_GREEN, RGB_GREEN, 1'b0, 4);
        inFlash = 1'b1;
        run_phase("night_green_b", L_GREEN,  RGB_GREEN,  1'b0, 8);
        run_phase("night_yellow",  L_YELLOW, RGB_YELLOW, 1'b0, 8);
        run_phase("night_flash_1", L_FLASH,  RGB_YELLOW, 1'b0, 8);
        run_phase("night_flash_0", L_FLASH,  RGB_OFF,    1'b0, 8);
        run_phase("night_flash_2", L_FLASH,  RGB_YELLOW, 1'b0, 3);
        inFlash = 1'b0;
        run_phase("night_flash_3", L_FLASH,  RGB_YELLOW, 1'b0, 1);
        run_phase("night_red",     L_RED,    RGB_RED,    1'b0, 8);

        $display("[TB] flash over walk priority");
        run_phase("prio_green_a", L_GREEN, RGB_GREEN, 1'b0, 1);
        inPedestrian = 2'b01;
        run_phase("prio_green_b", L_GREEN, RGB_GREEN, 1'b0, 1);
        inPedestrian = 2'b00;
        run_phase("prio_green_c", L_GREEN,  RGB_GREEN,  1'b1, 10);
        run_phase("prio_yellow",  L_YELLOW, RGB_YELLOW, 1'b1, 8);
        run_phase("prio_red_a",   L_RED,    RGB_RED,    1'b1, 1);
        inFlash = 1'b1;
        run_phase("prio_red_b",   L_RED,    RGB_RED,    1'b1, 7);
        run_phase("prio_flash_1", L_FLASH,  RGB_YELLOW, 1'b1, 8);
        inFlash = 1'b0;
        run_phase("prio_flash_0", L_FLASH,  RGB_OFF,    1'b1, 1);
        run_phase("prio_red2",    L_RED,    RGB_RED,    1'b1, 8);
        run_phase("prio_walk",    L_WALK,   RGB_WALK,   1'b0, 12);
        run_phase("prio_clear",   L_CLEAR,  RGB_RED,    1'b0, 4);

        $display("[TB] asynchronous reset");
        run_phase("rst_green_a", L_GREEN, RGB_GREEN, 1'b0, 1);
        inPedestrian = 2'b11;
        run_phase("rst_green_b", L_GREEN, RGB_GREEN, 1'b0, 1);
        inPedestrian = 2'b00;
        run_phase("rst_green_c", L_GREEN,  RGB_GREEN,  1'b1, 10);
        run_phase("rst_yellow",  L_YELLOW, RGB_YELLOW, 1'b1, 3);
        #2 rstb = 1'b0;
        #1 check_output("rst_async", L_RED, RGB_RED, 1'b0);
        @(negedge clk);
        check_output("rst_hold", L_RED, RGB_RED, 1'b0);
        rstb = 1'b1;
        run_phase("rst_red",   L_RED,   RGB_RED,   1'b0, 8);
        run_phase("rst_green", L_GREEN, RGB_GREEN, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
